// File: rtl/fp_core_driver_pkg.sv
// Shared FPU definitions used by the FP core driver slice: fflags layout,
// opcode/rounding widths and a few opcode encodings.
package fp_core_driver_pkg;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  localparam int FFLAGS_BITS   = $bits(fflags_t);
  localparam int INST_FPU_BITS = 4;
  localparam int INST_FRM_BITS = 3;

  localparam logic [INST_FPU_BITS-1:0] INST_FPU_ADD   = 4'h0;
  localparam logic [INST_FPU_BITS-1:0] INST_FPU_MUL   = 4'h2;
  localparam logic [INST_FPU_BITS-1:0] INST_FPU_CMP   = 4'hC;
  localparam logic [INST_FPU_BITS-1:0] INST_FPU_MISC  = 4'hE;

endpackage

// File: rtl/fp_core_driver_if.sv
// Request/response channel between the FP core driver (master) and a
// pipelined FP execution core (slave).
interface fp_core_driver_if
  import fp_core_driver_pkg::*;
#(
  parameter int LANES = 1,
  parameter int TAGW  = 2
);
  logic                           core_valid_in;
  logic                           core_ready_in;
  logic [TAGW-1:0]                core_tag_in;
  logic [INST_FPU_BITS-1:0]       core_op_type;
  logic [INST_FRM_BITS-1:0]       core_frm;
  logic [LANES*32-1:0]            core_dataa;
  logic [LANES*32-1:0]            core_datab;
  logic                           core_valid_out;
  logic                           core_ready_out;
  logic [TAGW-1:0]                core_tag_out;
  logic [LANES*32-1:0]            core_result;
  logic                           core_has_fflags;
  logic [LANES*FFLAGS_BITS-1:0]   core_fflags;

  modport master (
    output core_valid_in, core_tag_in, core_op_type, core_frm, core_dataa, core_datab,
    output core_ready_out,
    input  core_ready_in, core_valid_out, core_tag_out, core_result,
    input  core_has_fflags, core_fflags
  );

  modport slave (
    input  core_valid_in, core_tag_in, core_op_type, core_frm, core_dataa, core_datab,
    input  core_ready_out,
    output core_ready_in, core_valid_out, core_tag_out, core_result,
    output core_has_fflags, core_fflags
  );
endinterface

// File: rtl/fp_core_driver_chk.sv
// Protocol checker for the FP core driver: a returning tag must be one that
// is currently allocated, and the outstanding count stays in range.
module fp_core_driver_chk #(
  parameter int TAGW = 2
) (
  input logic                 clk,
  input logic                 reset,
  input logic                 rsp_fire,
  input logic [TAGW-1:0]      rsp_tag,
  input logic [(2**TAGW)-1:0] free_mask,
  input logic [TAGW:0]        pending
);
  localparam int NUM_TAGS = 2**TAGW;

  a_rsp_tag_allocated: assert property (@(posedge clk) disable iff (reset)
    rsp_fire |-> !free_mask[rsp_tag]);

  a_pending_range: assert property (@(posedge clk) disable iff (reset)
    pending <= NUM_TAGS[TAGW:0]);
endmodule

// File: rtl/fp_core_driver_tag_alloc.sv
// Core tag free list: lowest-index-free allocation, release by tag and an
// outstanding-tag counter with full/empty flags.
module fp_tag_alloc #(
  parameter int TAGW = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alloc_en,
  output logic [TAGW-1:0]        alloc_tag,
  input  logic                   release_en,
  input  logic [TAGW-1:0]        release_tag,
  output logic [(2**TAGW)-1:0]   free_mask,
  output logic                   full,
  output logic                   empty,
  output logic [TAGW:0]          pending
);
  localparam int NUM_TAGS = 2**TAGW;

  logic [NUM_TAGS-1:0] free_mask_r;
  logic [NUM_TAGS-1:0] free_mask_nxt_s;
  logic [TAGW:0]       pending_r;
  logic [TAGW:0]       pending_nxt_s;
  logic [TAGW-1:0]     alloc_tag_s;

  function automatic logic [TAGW-1:0] lowest_free(input logic [NUM_TAGS-1:0] mask);
    logic [TAGW-1:0] idx;
    idx = {TAGW{1'b0}};
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx = i[TAGW-1:0];
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Allocation always looks at the registered mask, so a tag released this
  // cycle is only handed out again from the next cycle on.
  always_comb begin
    alloc_tag_s     = lowest_free(free_mask_r);
    free_mask_nxt_s = free_mask_r;
    for (int i = 0; i < NUM_TAGS; i++) begin
      free_mask_nxt_s[i] = (free_mask_r[i] & ~(alloc_en && (alloc_tag_s == i[TAGW-1:0])))
                         | (release_en && (release_tag == i[TAGW-1:0]));
    end
  end

  // Next outstanding count: simultaneous alloc and release cancel out.
  always_comb begin
    pending_nxt_s = pending_r;
    case ({alloc_en, release_en})
      2'b10:   pending_nxt_s = pending_r + {{TAGW{1'b0}}, 1'b1};
      2'b01:   pending_nxt_s = pending_r - {{TAGW{1'b0}}, 1'b1};
      default: pending_nxt_s = pending_r;
    endcase
  end

  // Free mask and counter state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      free_mask_r <= {NUM_TAGS{1'b1}};
      pending_r   <= {(TAGW+1){1'b0}};
    end else begin
      free_mask_r <= free_mask_nxt_s;
      pending_r   <= pending_nxt_s;
    end
  end

  assign alloc_tag = alloc_tag_s;
  assign free_mask = free_mask_r;
  assign full      = ~(|free_mask_r);
  assign empty     = (pending_r == {(TAGW+1){1'b0}});
  assign pending   = pending_r;
endmodule

// File: rtl/fp_core_driver.sv
// Initiator front end for pipelined FP execution cores: tag allocation,
// metadata parking and registered request/response paths.
// Optional build macro FPU_FFLAGS_EN: reduce and return per-lane fflags.
module fp_core_driver
  import fp_core_driver_pkg::*;
#(
  parameter int LANES  = 1,
  parameter int META_W = 8,
  parameter int TAGW   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [META_W-1:0]          req_meta,
  input  logic [INST_FPU_BITS-1:0]   req_op_type,
  input  logic [INST_FRM_BITS-1:0]   req_frm,
  input  logic [LANES*32-1:0]        req_dataa,
  input  logic [LANES*32-1:0]        req_datab,
  fp_core_driver_if.master           core,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [META_W-1:0]          rsp_meta,
  output logic [LANES*32-1:0]        rsp_result,
  output logic                       rsp_has_fflags,
  output logic [FFLAGS_BITS-1:0]     rsp_fflags,
  output logic [TAGW:0]              pending,
  output logic                       empty
);
  localparam int NUM_TAGS = 2**TAGW;
  localparam int DW       = LANES * 32;

  logic                     req_ready_s;
  logic                     req_fire_s;
  logic                     core_req_fire_s;
  logic                     core_ready_out_s;
  logic                     core_rsp_fire_s;
  logic                     rsp_fire_s;
  logic                     full_s;
  logic                     empty_s;
  logic [TAGW-1:0]          alloc_tag_s;
  logic [NUM_TAGS-1:0]      free_mask_s;
  logic [TAGW:0]            pending_s;

  logic                     core_valid_r;
  logic [TAGW-1:0]          core_tag_r;
  logic [INST_FPU_BITS-1:0] core_op_r;
  logic [INST_FRM_BITS-1:0] core_frm_r;
  logic [DW-1:0]            core_dataa_r;
  logic [DW-1:0]            core_datab_r;
  logic [META_W-1:0]        meta_table_r [NUM_TAGS];
  logic                     rsp_valid_r;
  logic [META_W-1:0]        rsp_meta_r;
  logic [DW-1:0]            rsp_result_r;

  // Handshake decode; valids come only from flops, readies may look downstream.
  always_comb begin
    req_ready_s      = !full_s && (!core_valid_r || core.core_ready_in);
    req_fire_s       = req_valid && req_ready_s;
    core_req_fire_s  = core_valid_r && core.core_ready_in;
    core_ready_out_s = !rsp_valid_r || rsp_ready;
    core_rsp_fire_s  = core.core_valid_out && core_ready_out_s;
    rsp_fire_s       = rsp_valid_r && rsp_ready;
  end

  fp_tag_alloc #(.TAGW(TAGW)) u_tag_alloc (
    .clk         (clk),
    .reset       (reset),
    .alloc_en    (req_fire_s),
    .alloc_tag   (alloc_tag_s),
    .release_en  (core_rsp_fire_s),
    .release_tag (core.core_tag_out),
    .free_mask   (free_mask_s),
    .full        (full_s),
    .empty       (empty_s),
    .pending     (pending_s)
  );

  // Core request register; a new fire may replace a payload the core takes this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core_valid_r <= 1'b0;
      core_tag_r   <= {TAGW{1'b0}};
      core_op_r    <= {INST_FPU_BITS{1'b0}};
      core_frm_r   <= {INST_FRM_BITS{1'b0}};
      core_dataa_r <= {DW{1'b0}};
      core_datab_r <= {DW{1'b0}};
    end else if (req_fire_s) begin
      core_valid_r <= 1'b1;
      core_tag_r   <= alloc_tag_s;
      core_op_r    <= req_op_type;
      core_frm_r   <= req_frm;
      core_dataa_r <= req_dataa;
      core_datab_r <= req_datab;
    end else if (core_req_fire_s) begin
      core_valid_r <= 1'b0;
    end else begin
      core_valid_r <= core_valid_r;
    end
  end

  // Metadata parked by tag until the core hands the tag back.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_TAGS; i++) begin
        meta_table_r[i] <= {META_W{1'b0}};
      end
    end else if (req_fire_s) begin
      meta_table_r[alloc_tag_s] <= req_meta;
    end else begin
      meta_table_r[alloc_tag_s] <= meta_table_r[alloc_tag_s];
    end
  end

  // Writeback response register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_r  <= 1'b0;
      rsp_meta_r   <= {META_W{1'b0}};
      rsp_result_r <= {DW{1'b0}};
    end else if (core_rsp_fire_s) begin
      rsp_valid_r  <= 1'b1;
      rsp_meta_r   <= meta_table_r[core.core_tag_out];
      rsp_result_r <= core.core_result;
    end else if (rsp_fire_s) begin
      rsp_valid_r  <= 1'b0;
    end else begin
      rsp_valid_r  <= rsp_valid_r;
    end
  end

`ifdef FPU_FFLAGS_EN
  logic [FFLAGS_BITS-1:0] lane_or_s;
  logic [FFLAGS_BITS-1:0] fflags_masked_s;
  logic [FFLAGS_BITS-1:0] rsp_fflags_r;
  logic                   rsp_has_fflags_r;

  // OR of all lane flags, zeroed when the core reports no flags.
  always_comb begin
    lane_or_s = {FFLAGS_BITS{1'b0}};
    for (int l = 0; l < LANES; l++) begin
      lane_or_s = lane_or_s | core.core_fflags[l*FFLAGS_BITS +: FFLAGS_BITS];
    end
    if (core.core_has_fflags) begin
      fflags_masked_s = lane_or_s;
    end else begin
      fflags_masked_s = {FFLAGS_BITS{1'b0}};
    end
  end

  // fflags part of the response register, loaded alongside the result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_fflags_r     <= {FFLAGS_BITS{1'b0}};
      rsp_has_fflags_r <= 1'b0;
    end else if (core_rsp_fire_s) begin
      rsp_fflags_r     <= fflags_masked_s;
      rsp_has_fflags_r <= core.core_has_fflags;
    end else begin
      rsp_fflags_r     <= rsp_fflags_r;
      rsp_has_fflags_r <= rsp_has_fflags_r;
    end
  end

  assign rsp_fflags     = rsp_fflags_r;
  assign rsp_has_fflags = rsp_has_fflags_r;
`else
  logic unused_fflags_s;
  assign unused_fflags_s = ^{core.core_fflags, core.core_has_fflags};
  assign rsp_fflags      = {FFLAGS_BITS{1'b0}};
  assign rsp_has_fflags  = 1'b0;
`endif

  fp_core_driver_chk #(.TAGW(TAGW)) u_chk (
    .clk       (clk),
    .reset     (reset),
    .rsp_fire  (core_rsp_fire_s),
    .rsp_tag   (core.core_tag_out),
    .free_mask (free_mask_s),
    .pending   (pending_s)
  );

  assign req_ready           = req_ready_s;
  assign core.core_valid_in  = core_valid_r;
  assign core.core_tag_in    = core_tag_r;
  assign core.core_op_type   = core_op_r;
  assign core.core_frm       = core_frm_r;
  assign core.core_dataa     = core_dataa_r;
  assign core.core_datab     = core_datab_r;
  assign core.core_ready_out = core_ready_out_s;
  assign rsp_valid           = rsp_valid_r;
  assign rsp_meta            = rsp_meta_r;
  assign rsp_result          = rsp_result_r;
  assign pending             = pending_s;
  assign empty               = empty_s;
endmodule

// File: tb/tb_fp_core_driver.sv
// Self-checking bench for fp_core_driver: directed scenarios plus random
// traffic compared against a tag-pool / scoreboard reference model.
module tb_fp_core_driver;
  import fp_core_driver_pkg::*;

  localparam int LANES    = 4;
  localparam int META_W   = 8;
  localparam int TAGW     = 2;
  localparam int NUM_TAGS = 4;
  localparam int DW       = LANES * 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic                     req_valid;
  logic                     req_ready;
  logic [META_W-1:0]        req_meta;
  logic [INST_FPU_BITS-1:0] req_op_type;
  logic [INST_FRM_BITS-1:0] req_frm;
  logic [DW-1:0]            req_dataa;
  logic [DW-1:0]            req_datab;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [META_W-1:0]        rsp_meta;
  logic [DW-1:0]            rsp_result;
  logic                     rsp_has_fflags;
  logic [FFLAGS_BITS-1:0]   rsp_fflags;
  logic [TAGW:0]            pending;
  logic                     empty;

  fp_core_driver_if #(.LANES(LANES), .TAGW(TAGW)) cif ();

  fp_core_driver #(.LANES(LANES), .META_W(META_W), .TAGW(TAGW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_meta(req_meta),
    .req_op_type(req_op_type), .req_frm(req_frm),
    .req_dataa(req_dataa), .req_datab(req_datab),
    .core(cif.master),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_meta(rsp_meta),
    .rsp_result(rsp_result), .rsp_has_fflags(rsp_has_fflags), .rsp_fflags(rsp_fflags),
    .pending(pending), .empty(empty)
  );

  // reference model state
  bit                       m_free [NUM_TAGS];
  logic [META_W-1:0]        m_meta [NUM_TAGS];
  int                       m_pending;
  bit                       m_cv;
  int                       m_ctag;
  logic [INST_FPU_BITS-1:0] m_cop;
  logic [INST_FRM_BITS-1:0] m_cfrm;
  logic [DW-1:0]            m_ca, m_cb;
  bit                       m_rv;
  logic [META_W-1:0]        m_rmeta;
  logic [DW-1:0]            m_rresult;
  bit                       m_rhas;
  logic [FFLAGS_BITS-1:0]   m_rflags;
  int                       core_held [$];
  bit                       last_crsp_fired;
  int                       dut_rsp_fires;
  int                       checks;
  int                       failures;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int lowest_free();
    for (int i = 0; i < NUM_TAGS; i++) if (m_free[i]) return i;
    return -1;
  endfunction

  function automatic logic [FFLAGS_BITS-1:0] exp_flags();
    logic [FFLAGS_BITS-1:0] acc;
    acc = '0;
`ifdef FPU_FFLAGS_EN
    if (cif.core_has_fflags)
      for (int l = 0; l < LANES; l++) acc = acc | cif.core_fflags[l*FFLAGS_BITS +: FFLAGS_BITS];
`endif
    return acc;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_TAGS; i++) begin m_free[i] = 1'b1; m_meta[i] = '0; end
    m_pending = 0; m_cv = 0; m_ctag = 0; m_cop = '0; m_cfrm = '0; m_ca = '0; m_cb = '0;
    m_rv = 0; m_rmeta = '0; m_rresult = '0; m_rhas = 0; m_rflags = '0;
    core_held.delete();
    last_crsp_fired = 0;
  endtask

  // One clock: compare at the falling edge, advance the model, return at posedge+1.
  task automatic step();
    bit exp_ready, exp_cro, req_f, creq_f, crsp_f, rsp_f;
    int t;
    @(negedge clk);
    exp_ready = (m_pending < NUM_TAGS) && (!m_cv || cif.core_ready_in);
    exp_cro   = !m_rv || rsp_ready;
    check_val("req_ready", DW'(req_ready), DW'(exp_ready));
    check_val("core_valid_in", DW'(cif.core_valid_in), DW'(m_cv));
    check_val("core_ready_out", DW'(cif.core_ready_out), DW'(exp_cro));
    check_val("rsp_valid", DW'(rsp_valid), DW'(m_rv));
    check_val("pending", DW'(pending), DW'(m_pending));
    check_val("empty", DW'(empty), DW'(m_pending == 0));
    if (m_cv) begin
      check_val("core_tag_in", DW'(cif.core_tag_in), DW'(m_ctag));
      check_val("core_op", DW'({cif.core_op_type, cif.core_frm}), DW'({m_cop, m_cfrm}));
      check_val("core_dataa", cif.core_dataa, m_ca);
      check_val("core_datab", cif.core_datab, m_cb);
    end
    if (m_rv) begin
      check_val("rsp_meta", DW'(rsp_meta), DW'(m_rmeta));
      check_val("rsp_result", rsp_result, m_rresult);
      check_val("rsp_fflags", DW'({rsp_has_fflags, rsp_fflags}), DW'({m_rhas, m_rflags}));
    end
    if (rsp_valid && rsp_ready) dut_rsp_fires++;
    req_f  = req_valid && exp_ready;
    creq_f = m_cv && cif.core_ready_in;
    crsp_f = cif.core_valid_out && exp_cro;
    rsp_f  = m_rv && rsp_ready;
    if (creq_f) core_held.push_back(m_ctag);
    if (req_f) begin
      t = lowest_free();
      m_free[t] = 1'b0; m_meta[t] = req_meta;
      m_cv = 1; m_ctag = t; m_cop = req_op_type; m_cfrm = req_frm;
      m_ca = req_dataa; m_cb = req_datab;
    end else if (creq_f) begin
      m_cv = 0;
    end
    if (crsp_f) begin
      t = int'(cif.core_tag_out);
      m_rv = 1; m_rmeta = m_meta[t]; m_rresult = cif.core_result;
`ifdef FPU_FFLAGS_EN
      m_rhas = cif.core_has_fflags;
`else
      m_rhas = 0;
`endif
      m_rflags = exp_flags();
      m_free[t] = 1'b1;
      foreach (core_held[i]) if (core_held[i] == t) begin core_held.delete(i); break; end
    end else if (rsp_f) begin
      m_rv = 0;
    end
    m_pending = m_pending + int'(req_f) - int'(crsp_f);
    last_crsp_fired = crsp_f;
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [META_W-1:0] meta);
    req_valid = 1'b1; req_meta = meta;
    req_op_type = 4'($urandom); req_frm = 3'($urandom);
    req_dataa = {$urandom, $urandom, $urandom, $urandom};
    req_datab = {$urandom, $urandom, $urandom, $urandom};
    step();
    req_valid = 1'b0;
  endtask

  task automatic respond(input int tag);
    cif.core_valid_out = 1'b1; cif.core_tag_out = 2'(tag);
    cif.core_result = {$urandom, $urandom, $urandom, $urandom};
    step();
    cif.core_valid_out = 1'b0;
  endtask

  int order [4] = '{2, 0, 3, 1};
  int fires0;

  initial begin
    checks = 0; failures = 0; dut_rsp_fires = 0;
    req_valid = 0; req_meta = '0; req_op_type = '0; req_frm = '0; req_dataa = '0; req_datab = '0;
    rsp_ready = 0;
    cif.core_ready_in = 0; cif.core_valid_out = 0; cif.core_tag_out = '0;
    cif.core_result = '0; cif.core_has_fflags = 0; cif.core_fflags = '0;
    model_reset();
    reset = 1'b1;
    #12;
    check_val("rst_req_ready", DW'(req_ready), DW'(1));
    check_val("rst_core_valid", DW'(cif.core_valid_in), DW'(0));
    check_val("rst_core_ready_out", DW'(cif.core_ready_out), DW'(1));
    check_val("rst_rsp", DW'({rsp_valid, rsp_has_fflags, rsp_fflags}), DW'(0));
    check_val("rst_pending", DW'({pending, empty}), DW'({3'd0, 1'b1}));
    check_val("rst_payload", rsp_result | cif.core_dataa | DW'({rsp_meta, cif.core_tag_in}), DW'(0));
    @(posedge clk); #1; reset = 1'b0;
    step();

    // single request, 2-cycle core latency
    rsp_ready = 1;
    issue(8'h5A);
    check_val("t1_valid_tag", DW'({cif.core_valid_in, cif.core_tag_in}), DW'({1'b1, 2'd0}));
    cif.core_ready_in = 1; step(); cif.core_ready_in = 0;
    step(); step();
    check_val("t1_pending1", DW'(pending), DW'(1));
    respond(0);
    check_val("t1_rsp_meta", DW'({rsp_valid, rsp_meta}), DW'({1'b1, 8'h5A}));
    check_val("t1_pending0", DW'(pending), DW'(0));
    step();

    // fill the free list
    cif.core_ready_in = 1;
    for (int i = 0; i < 4; i++) begin
      issue(8'h10 + 8'(i));
      check_val("t2_tag", DW'(cif.core_tag_in), DW'(i));
    end
    check_val("t2_full", DW'({req_ready, pending}), DW'({1'b0, 3'd4}));
    step();

    // out-of-order return, freed tag 2 reused next
    for (int k = 0; k < 4; k++) begin
      respond(order[k]);
      check_val("t3_rsp_meta", DW'(rsp_meta), DW'(8'h10 + 8'(order[k])));
      if (k == 0) begin
        issue(8'hA7);
        check_val("t3_realloc_tag", DW'(cif.core_tag_in), DW'(2));
        step();
      end
    end
    respond(2);
    check_val("t3_rsp_meta_a7", DW'(rsp_meta), DW'(8'hA7));
    step();

    // downstream backpressure
    issue(8'h31); issue(8'h32); step();
    rsp_ready = 0;
    respond(0);
    cif.core_valid_out = 1; cif.core_tag_out = 2'd1;
    fires0 = dut_rsp_fires;
    for (int i = 0; i < 5; i++) begin
      step();
      check_val("t4_stall", DW'({cif.core_ready_out, rsp_valid, rsp_meta}), DW'({1'b0, 1'b1, 8'h31}));
    end
    rsp_ready = 1; step();
    check_val("t4_one_fire", DW'(dut_rsp_fires - fires0), DW'(1));
    check_val("t4_next_meta", DW'(rsp_meta), DW'(8'h32));
    cif.core_valid_out = 0; step();

    // fflags lane reduction
    issue(8'h44); issue(8'h45); step();
    cif.core_has_fflags = 1;
    cif.core_fflags = {5'h00, 5'h01, 5'h00, 5'h10};
    respond(0);
`ifdef FPU_FFLAGS_EN
    check_val("t5_fflags", DW'({rsp_has_fflags, rsp_fflags}), DW'({1'b1, 5'h11}));
`else
    check_val("t5_fflags", DW'({rsp_has_fflags, rsp_fflags}), DW'({1'b0, 5'h00}));
`endif
    cif.core_has_fflags = 0;
    respond(1);
    check_val("t5_fflags_masked", DW'({rsp_has_fflags, rsp_fflags}), DW'(0));
    step();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      req_valid = ($urandom_range(0, 99) < 60);
      req_meta = 8'($urandom); req_op_type = 4'($urandom); req_frm = 3'($urandom);
      req_dataa = {$urandom, $urandom, $urandom, $urandom};
      req_datab = {$urandom, $urandom, $urandom, $urandom};
      cif.core_ready_in = ($urandom_range(0, 99) < 70);
      if (!(cif.core_valid_out && !last_crsp_fired)) begin
        if (core_held.size() > 0 && $urandom_range(0, 99) < 50) begin
          cif.core_valid_out = 1;
          cif.core_tag_out = 2'(core_held[$urandom_range(0, core_held.size() - 1)]);
          cif.core_result = {$urandom, $urandom, $urandom, $urandom};
          cif.core_has_fflags = 1'($urandom);
          cif.core_fflags = 20'($urandom);
        end else begin
          cif.core_valid_out = 0;
        end
      end
      rsp_ready = ($urandom_range(0, 99) < 70);
      step();
    end

    // drain
    req_valid = 0; cif.core_ready_in = 1; rsp_ready = 1;
    for (int c = 0; c < 100 && (m_cv || core_held.size() > 0 || m_pending != 0); c++) begin
      cif.core_valid_out = (core_held.size() > 0);
      if (core_held.size() > 0) cif.core_tag_out = 2'(core_held[0]);
      step();
    end
    cif.core_valid_out = 0; step();
    check_val("drain_pending", DW'(pending), DW'(0));

    // reset with three tags outstanding
    rsp_ready = 0;
    for (int i = 0; i < 4; i++) issue(8'hC0 + 8'(i));
    step();
    respond(core_held[0]);
    check_val("t6_pre", DW'({pending, rsp_valid}), DW'({3'd3, 1'b1}));
    #2 reset = 1'b1;
    #1;
    check_val("t6_rst_state", DW'({pending, empty, rsp_valid, cif.core_valid_in, req_ready}),
              DW'({3'd0, 1'b1, 1'b0, 1'b0, 1'b1}));
    model_reset();
    @(posedge clk); #1; reset = 1'b0;
    rsp_ready = 1;
    issue(8'h77);
    check_val("t6_tag_after_rst", DW'(cif.core_tag_in), DW'(0));
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
